shift4_reg: RTL and testbench



---
 rtl/shift4_reg_pkg.sv | 13 +
 rtl/shift4_reg_if.sv | 32 +++
 rtl/shift4_reg.sv | 43 ++++
 tb/tb_shift4_reg.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/shift4_reg_pkg.sv
// +----------------------------------------------------------------------------+
// | shift4_reg_pkg : shared constants for the multiplier operand shift register |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package shift4_reg_pkg;

  localparam int DEFAULT_WIDTH = 4;

endpackage : shift4_reg_pkg

`default_nettype wire

// File: rtl/shift4_reg_if.sv
// +----------------------------------------------------------------------------+
// | shift4_reg_if : control, data and observation signals of shift4_reg        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface shift4_reg_if
  import shift4_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] loadValue;
  logic             shift;
  logic             shiftIn;
  logic [WIDTH-1:0] shiftReg;
  logic             shiftOut;

  modport master (
    output load, loadValue, shift, shiftIn,
    input  shiftReg, shiftOut
  );

  modport slave (
    input  load, loadValue, shift, shiftIn,
    output shiftReg, shiftOut
  );

endinterface : shift4_reg_if

`default_nettype wire

// File: rtl/shift4_reg.sv
// +----------------------------------------------------------------------------+
// | shift4_reg : parallel-load, right-shifting register with serial in/out     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift4_reg
  import shift4_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic       clock,
  input  wire logic       reset,
  shift4_reg_if.slave     bus
);

  logic [WIDTH-1:0] r_shift_reg;
  logic [WIDTH-1:0] w_next;

  // Load takes priority over shift; the old LSB falls off on a shift.
  always_comb begin
    w_next = r_shift_reg;
    if (bus.load) begin
      w_next = bus.loadValue;
    end else if (bus.shift) begin
      w_next = {bus.shiftIn, r_shift_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift_reg <= '0;
    end else begin
      r_shift_reg <= w_next;
    end
  end

  assign bus.shiftReg = r_shift_reg;
  assign bus.shiftOut = r_shift_reg[0];

endmodule : shift4_reg

`default_nettype wire

// File: tb/tb_shift4_reg.sv
// +----------------------------------------------------------------------------+
// | tb_shift4_reg : self-checking bench for shift4_reg against a reference model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shift4_reg;

  localparam int W = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q = '0;

  shift4_reg_if #(.WIDTH(W)) bus ();

  shift4_reg #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] model_next(input logic [W-1:0] s, input logic ld,
                                              input logic [W-1:0] lv, input logic sh,
                                              input logic si);
    int v;
    if (ld) return lv;
    if (!sh) return s;
    v = int'(s) / 2 + (si ? (1 << (W - 1)) : 0);
    return W'(v);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_both(input string tag);
    chk({tag, ".reg"}, bus.shiftReg, exp_q);
    chk({tag, ".out"}, {{(W-1){1'b0}}, bus.shiftOut}, {{(W-1){1'b0}}, exp_q[0]});
  endtask

  // Drive at negedge, advance one rising edge, update model, sample 1ns later.
  task automatic step(input logic ld, input logic [W-1:0] lv, input logic sh, input logic si);
    @(negedge clock);
    bus.load      = ld;
    bus.loadValue = lv;
    bus.shift     = sh;
    bus.shiftIn   = si;
    @(posedge clock);
    if (reset) exp_q = model_next(exp_q, ld, lv, sh, si);
    #1;
  endtask

  initial begin
    logic [W-1:0] v;
    logic ld, sh, si;

    // Reset held low with a pending load: register must stay clear.
    bus.load = 1'b1; bus.loadValue = 4'hF; bus.shift = 1'b0; bus.shiftIn = 1'b0;
    #1;
    chk_both("reset_t1");
    @(posedge clock); #1;
    chk_both("reset_t2");
    @(posedge clock); #1;
    chk_both("reset_t3");
    @(negedge clock);
    bus.load = 1'b0;
    reset = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk_both("after_release");

    // Load then single shift, then hold.
    step(1'b1, 4'b1011, 1'b0, 1'b0);
    chk_both("load_1011");
    step(1'b0, 4'h0, 1'b1, 1'b1);
    chk("shift_once", bus.shiftReg, 4'b1101);
    chk_both("shift_once_m");
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      chk("hold_1101", bus.shiftReg, 4'b1101);
    end

    // Random loads, idle hold, one shift with shiftIn=1.
    for (int i = 0; i < 10; i++) begin
      v = W'($urandom_range(0, 15));
      step(1'b1, v, 1'b0, 1'b0);
      chk_both("rnd_load");
      for (int j = 0; j < 3; j++) begin
        step(1'b0, W'($urandom), 1'b0, 1'($urandom));
        chk("rnd_hold", bus.shiftReg, v);
      end
      step(1'b0, 4'h0, 1'b1, 1'b1);
      chk("rnd_shift", bus.shiftReg, {1'b1, v[3:1]});
    end

    // Load beats shift when both are high.
    step(1'b1, 4'b0110, 1'b0, 1'b0);
    step(1'b1, 4'b1001, 1'b1, 1'b1);
    chk("load_priority", bus.shiftReg, 4'b1001);

    // Full drain: LSB-first serial output 0,1,0,1.
    step(1'b1, 4'b1010, 1'b0, 1'b0);
    chk("drain_out0", {3'b0, bus.shiftOut}, 4'd0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain_out1", {3'b0, bus.shiftOut}, 4'd1);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain_out2", {3'b0, bus.shiftOut}, 4'd0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain_out3", {3'b0, bus.shiftOut}, 4'd1);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain_final", bus.shiftReg, 4'b0000);

    // Constant shiftIn=1 for W shifts fills with ones.
    for (int i = 0; i < W; i++) step(1'b0, 4'h0, 1'b1, 1'b1);
    chk("fill_ones", bus.shiftReg, 4'b1111);

    // Randomised mixed traffic against the model.
    for (int i = 0; i < 60; i++) begin
      ld = 1'($urandom_range(0, 3) == 0);
      sh = 1'($urandom);
      si = 1'($urandom);
      step(ld, W'($urandom), sh, si);
      chk_both("rnd_mix");
    end

    // Asynchronous reset between edges clears before the next rising edge.
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    chk("pre_async", bus.shiftReg, 4'b1111);
    #2;
    reset = 1'b0;
    exp_q = '0;
    #1;
    chk_both("async_clear");
    step(1'b1, 4'b0101, 1'b1, 1'b1);
    chk_both("reset_ignores_load");
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 4'b0101, 1'b0, 1'b0);
    chk("post_reset_load", bus.shiftReg, 4'b0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shift4_reg

`default_nettype wire
